seq_det_prog: RTL and testbench
===============================

Name: seq_det_prog

Overview:
- Parametrised successor to the team's fixed-pattern Moore sequence detector.
- Detects a run-time programmable serial bit pattern of 1..MAX_LEN bits on a valid-qualified serial input.
- Supports overlapping and non-overlapping match modes, a registered Moore-style match pulse, and a saturating match counter.
- Sits after the serial front-end; Y feeds the frame-sync / event logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, 4, width of cfg_len; must hold MAX_LEN, i.e. LEN_W >= clog2(MAX_LEN+1).
- CNT_W, 16, width of the match counter.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  load cfg_pat/cfg_len/cfg_ovl this cycle.
- cfg_pat  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
- cfg_len  in  LEN_W  pattern length in bits.
- cfg_ovl  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- din_vld  in  1  din is valid this cycle.
- din  in  1  serial data bit.
- cnt_clr  in  1  clear match counter.
- Y  out  1  registered match pulse, one cycle per match.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst=1 at an edge) clears all of the following to 0:
  - pattern, len, ovl registers;
  - history, fill, hit;
  - Y and match_cnt.
- Reset overrides every other input and is effective mid-pattern.
- Config: on cfg_we=1, pat/len/ovl load, and history, fill and hit clear. din is ignored that cycle, even if din_vld=1.
- Effective length L:
  - cfg_len=0 → detector disabled (no matches);
  - cfg_len>MAX_LEN → L=MAX_LEN.
- History: MAX_LEN-bit shift register. On each din_vld=1 (no cfg_we), hist_next = {hist[MAX_LEN-2:0], din}.
- Fill counter: bits accepted since last clear, saturating at MAX_LEN. Cycles with din_vld=0 change nothing (gaps are transparent).
- Match condition, evaluated on the next-state values:
  - din_vld=1;
  - L>=1;
  - fill_next>=L;
  - hist_next[L-1:0] == pat[L-1:0].
- hit <= match condition on the same edge the last pattern bit is accepted.
- Y <= hit: Y is high for exactly one cycle, two edges after the edge that accepted the last pattern bit. This matches the existing Moore detector's latency.
- Back-to-back matches on consecutive valid bits (e.g. pattern "11", L=2, overlap) produce Y high on consecutive cycles.
- Overlap modes:
  - ovl=1: history and fill are untouched by a match; the tail of one match may start the next.
  - ovl=0: on a match edge, fill_next is forced to 0, so the next match needs L fresh bits.
- match_cnt:
  - increments by 1 on the edge where Y is set to 1;
  - saturates at all-ones;
  - cnt_clr=1 sets it to 0, and wins over a simultaneous increment.
- cfg_we takes priority over din_vld. A hit already registered before cfg_we is cleared, so no Y pulse for it.
- No combinational path from any input to Y or match_cnt.

Test Plan:
- Setup for the first three scenarios: rst, then cfg_we with pat=4'b1101, len=4, ovl=1. Stream 1,1,0,1 one bit per cycle → Y=1 for exactly one cycle, 2 edges after the 4th bit's edge; match_cnt=1.
- ovl=1, stream 1101101 → two Y pulses, 3 cycles apart; match_cnt=2. Repeat with ovl=0 → one pulse; match_cnt=1.
- Same pattern, din_vld low for 3 cycles between each bit → exactly one Y pulse, 2 edges after the last valid bit.
- pat=8'hA5, len=8, MAX_LEN=8: stream 0xA5 MSB-first → match. Then cfg_len=0 → no Y for any stream. Then cfg_len=15 → behaves as L=8.
- Mid-pattern reset and reconfig:
  - after 1,1,0 assert rst one cycle, then send 1 → no match;
  - repeat with cfg_we instead of rst → no match;
  - cfg_we in the cycle after the final bit → the pending hit is dropped and Y stays 0.
- CNT_W=2: generate 5 matches → match_cnt stays at 3. Assert cnt_clr on a match's increment edge → match_cnt=0.

Source files
------------

// File: rtl/seq_det_prog_if.sv
// Purpose : configuration, serial-data and result signals of the programmable sequence detector.
// Latency : none, wiring only.
// Backpressure: none; din is valid-qualified only and the detector always accepts.
// Ports (master drives / slave receives):
//   cfg_we, cfg_pat, cfg_len, cfg_ovl : pattern load strobe, pattern, length, overlap mode
//   din_vld, din                      : valid-qualified serial data bit
//   cnt_clr                           : match counter clear
//   Y, match_cnt                      : registered match pulse, saturating match count (slave drives)
interface seq_det_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_ovl;
  logic               din_vld;
  logic               din;
  logic               cnt_clr;
  logic               Y;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output cfg_we, cfg_pat, cfg_len, cfg_ovl, din_vld, din, cnt_clr,
    input  Y, match_cnt
  );

  modport slave (
    input  cfg_we, cfg_pat, cfg_len, cfg_ovl, din_vld, din, cnt_clr,
    output Y, match_cnt
  );
endinterface

// File: rtl/seq_det_prog.sv
// Purpose : detects a run-time programmable 1..MAX_LEN bit serial pattern, overlapping or not, with match counter.
// Latency : Y rises one edge after the edge that registers the hit (the edge accepting the last pattern bit).
// Backpressure: none; every din_vld bit is consumed, gaps with din_vld=0 are transparent.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_det_prog_if.slave carrying config, serial input, cnt_clr, Y and match_cnt
module seq_det_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_prog_if.slave bus
);

  logic [MAX_LEN-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0]   len_q,  len_d;
  logic               ovl_q,  ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               hit_q,  hit_d;
  logic               y_q,    y_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;

  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_sh;
  logic [LEN_W-1:0]   fill_inc;
  logic               match_c;

  always_comb begin
    eff_len  = len_q;
    mask     = '0;
    hist_sh  = {hist_q[MAX_LEN-2:0], bus.din};
    fill_inc = fill_q;
    match_c  = 1'b0;

    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    hit_d  = 1'b0;
    y_d    = 1'b0;
    cnt_d  = cnt_q;

    // Over-long lengths clamp to the full history width.
    if (len_q > LEN_W'(MAX_LEN)) begin
      eff_len = LEN_W'(MAX_LEN);
    end

    // Only the low eff_len history bits take part in the compare; eff_len=0 gives an empty mask.
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < eff_len);
    end

    if (fill_q < LEN_W'(MAX_LEN)) begin
      fill_inc = fill_q + LEN_W'(1);
    end

    match_c = bus.din_vld && !bus.cfg_we && (eff_len != '0) && (fill_inc >= eff_len)
              && (((hist_sh ^ pat_q) & mask) == '0);

    if (bus.cfg_we) begin
      pat_d  = bus.cfg_pat;
      len_d  = bus.cfg_len;
      ovl_d  = bus.cfg_ovl;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.din_vld) begin
      hist_d = hist_sh;
      // Non-overlapping mode demands eff_len fresh bits after every match.
      fill_d = (match_c && !ovl_q) ? '0 : fill_inc;
      hit_d  = match_c;
    end

    // A hit still pending when the pattern is reloaded must not surface on Y.
    y_d = hit_q && !bus.cfg_we;

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (y_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      hit_q  <= hit_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.Y         = y_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Purpose : directed bench for seq_det_prog; expected Y pulses are queued at stimulus time and checked by a monitor.
// Latency : a pulse is expected two edges after the edge on which its last pattern bit is driven in.
// Backpressure: none.
module tb_seq_det_prog;

  logic clk = 1'b0;
  logic rst;
  int   pos_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  seq_det_prog_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) bus ();

  seq_det_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int edge_n;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   vectors     = 0;
  int   miscompares = 0;

  // Monitor: every Y pulse must match the head of the expectation queue in time and count.
  always @(negedge clk) begin
    if (bus.Y === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0 || exp_q[0].edge_n != pos_cnt) begin
        miscompares++;
        $display("FAIL unexpected_Y at edge %0d: Y=1, expected 0", pos_cnt);
      end else begin
        cur = exp_q.pop_front();
        if (int'(bus.match_cnt) != cur.cnt) begin
          miscompares++;
          $display("FAIL pulse_cnt at edge %0d: match_cnt=%0d, expected %0d", pos_cnt, bus.match_cnt, cur.cnt);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].edge_n == pos_cnt) begin
      vectors++;
      miscompares++;
      $display("FAIL missed_Y at edge %0d: Y=%b, expected 1", pos_cnt, bus.Y);
      cur = exp_q.pop_front();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    bus.din_vld = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    bus.cfg_we  = 1'b1;
    bus.cfg_pat = p;
    bus.cfg_len = l;
    bus.cfg_ovl = o;
    tick();
    bus.cfg_we  = 1'b0;
  endtask

  // Drive one valid bit; when hit is set, a Y pulse carrying count cnt is expected two edges later.
  task automatic send(input logic b, input bit hit, input int cnt);
    exp_t e;
    bus.din_vld = 1'b1;
    bus.din     = b;
    if (hit) begin
      e.edge_n = pos_cnt + 2;
      e.cnt    = cnt;
      exp_q.push_back(e);
    end
    tick();
    bus.din_vld = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;
    rst         = 1'b1;
    bus.cfg_we  = 1'b0;
    bus.cfg_pat = '0;
    bus.cfg_len = '0;
    bus.cfg_ovl = 1'b0;
    bus.din_vld = 1'b0;
    bus.din     = 1'b0;
    bus.cnt_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_Y", int'(bus.Y), 0);
    chk("rst_cnt", int'(bus.match_cnt), 0);

    // Single match of 1101, overlap on.
    cfg(8'h0D, 4'd4, 1'b1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 1, 1);
    idle(3);
    chk("single_cnt", int'(bus.match_cnt), 1);

    // 1101101 with overlap: two pulses three cycles apart.
    do_rst();
    cfg(8'h0D, 4'd4, 1'b1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 1, 1);
    send(1, 0, 0); send(0, 0, 0); send(1, 1, 2);
    idle(3);
    chk("ovl_cnt", int'(bus.match_cnt), 2);

    // Same stream without overlap: the shared tail bit cannot be reused.
    do_rst();
    cfg(8'h0D, 4'd4, 1'b0);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 1, 1);
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
    idle(3);
    chk("novl_cnt", int'(bus.match_cnt), 1);

    // Gaps of three idle cycles between bits are transparent.
    do_rst();
    cfg(8'h0D, 4'd4, 1'b1);
    send(1, 0, 0); idle(3); send(1, 0, 0); idle(3);
    send(0, 0, 0); idle(3); send(1, 1, 1);
    idle(4);
    chk("gap_cnt", int'(bus.match_cnt), 1);

    // Full-width pattern, then disabled length, then clamped length.
    do_rst();
    cfg(8'hA5, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) send(a5[i], i == 0, 1);
    idle(3);
    chk("a5_cnt", int'(bus.match_cnt), 1);
    cfg(8'hA5, 4'd0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 7; i >= 0; i--) send(a5[i], 0, 0);
    end
    for (int i = 0; i < 6; i++) send(1'b1, 0, 0);
    idle(3);
    chk("len0_cnt", int'(bus.match_cnt), 1);
    cfg(8'hA5, 4'd15, 1'b1);
    for (int i = 7; i >= 0; i--) send(a5[i], i == 0, 2);
    idle(3);
    chk("len15_cnt", int'(bus.match_cnt), 2);

    // Mid-pattern reset: config is wiped, trailing 1 cannot match.
    do_rst();
    cfg(8'h0D, 4'd4, 1'b1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0);
    do_rst();
    send(1, 0, 0);
    idle(3);
    chk("midrst_cnt", int'(bus.match_cnt), 0);

    // Mid-pattern reconfig: history restarts, four fresh bits are needed.
    cfg(8'h0D, 4'd4, 1'b1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0);
    cfg(8'h0D, 4'd4, 1'b1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 1, 1);
    idle(3);
    chk("midcfg_cnt", int'(bus.match_cnt), 1);

    // Reconfig in the cycle after the final bit drops the pending hit.
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
    cfg(8'h0D, 4'd4, 1'b1);
    idle(3);
    chk("drop_Y", int'(bus.Y), 0);
    chk("drop_cnt", int'(bus.match_cnt), 1);

    // Pattern 11: back-to-back pulses, counter saturates at 3.
    do_rst();
    cfg(8'h03, 4'd2, 1'b1);
    send(1, 0, 0); send(1, 1, 1); send(1, 1, 2); send(1, 1, 3); send(1, 1, 3); send(1, 1, 3);
    idle(3);
    chk("sat_cnt", int'(bus.match_cnt), 3);

    // Clear on the increment edge of a match wins.
    send(1, 1, 0);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    idle(2);
    chk("clr_cnt", int'(bus.match_cnt), 0);
    send(1, 1, 1);
    idle(3);
    chk("post_clr_cnt", int'(bus.match_cnt), 1);

    idle(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
